// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - four-requester byte handshake bundle for the UART TX arbiter
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one 8N1 UART transmitter
// Grants one of four byte requesters while idle, then serializes the latched byte LSB first.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   bus,
    output logic               uart_tx,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic               frame_done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift_data, data_n;
    logic [1:0]  grant_n;
    logic        tx_n, done_n;
    logic [3:0]  ready_c;
    logic [1:0]  pick, cand;
    logic        found;

    // Search starts one past the last grant; i == 4 wraps back onto the last grant itself.
    always_comb begin
        pick  = grant_id;
        cand  = grant_id;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = grant_id + 2'(i);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        data_n    = shift_data;
        grant_n   = grant_id;
        done_n    = 1'b0;
        ready_c   = 4'b0000;
        case (state)
            IDLE: begin
                if (found) begin
                    ready_c[pick] = 1'b1;
                    data_n        = bus.req_data[{pick, 3'b000} +: 8];
                    grant_n       = pick;
                    cnt_n         = BIT_LAST;
                    state_n       = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    cnt_n     = BIT_LAST;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n = BIT_LAST;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is precomputed from the next state so uart_tx can be a plain register.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_n[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    // The accept pulse is combinational with the grant decision, so reset must mask it directly.
    assign bus.req_ready = reset_n ? ready_c : 4'b0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_data <= '0;
            grant_id   <= 2'd3;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift_data <= data_n;
            grant_id   <= grant_n;
            uart_tx    <= tx_n;
            busy       <= (state_n != IDLE);
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int CPB = 4;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_byte;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();
    uart_tx_arbiter_if bus1();

    logic       uart_tx, busy, frame_done;
    logic [1:0] grant_id;
    logic       uart_tx1, busy1, frame_done1;
    logic [1:0] grant_id1;

    uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .uart_tx(uart_tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    uart_tx_arbiter #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .uart_tx(uart_tx1), .busy(busy1), .grant_id(grant_id1), .frame_done(frame_done1)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    bit         rx_en = 1'b0;
    vec_t       vecs[12];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Line receiver: samples mid-bit and checks each frame against the scoreboard.
    initial begin
        logic [7:0] b;
        bit alive;
        forever begin
            @(negedge clk);
            if (rx_en && uart_tx === 1'b0) begin
                alive = 1'b1;
                b = 8'h00;
                repeat (CPB + CPB / 2) @(negedge clk);
                alive = rx_en;
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    if (alive) begin
                        repeat (CPB) @(negedge clk);
                        alive = rx_en;
                        b[i] = uart_tx;
                    end
                end
                if (alive) begin
                    repeat (CPB) @(negedge clk);
                    alive = rx_en;
                end
                if (alive) begin
                    check("rx_stop_bit", 32'(uart_tx), 32'd1);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rx_unexpected: got frame %02h expected none", b);
                    end else begin
                        check("rx_byte", 32'(b), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_grant(input string name, input logic [3:0] exp_ready,
                              input logic [7:0] exp_byte, output int gcyc);
        int t = 0;
        @(negedge clk);
        while (bus.req_ready == 4'b0000 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({name, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
        if (bus.req_ready != 4'b0000) sb.push_back(exp_byte);
        gcyc = cyc;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #300000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int g, gprev, rel, t;
        bit saw;
        logic [9:0] frame;

        vecs[0]  = '{4'b1111, 32'h33323130, 4'b0001, 2'd0, 8'h30};
        vecs[1]  = '{4'b1111, 32'h33323130, 4'b0010, 2'd1, 8'h31};
        vecs[2]  = '{4'b1111, 32'h33323130, 4'b0100, 2'd2, 8'h32};
        vecs[3]  = '{4'b1111, 32'h33323130, 4'b1000, 2'd3, 8'h33};
        vecs[4]  = '{4'b1111, 32'h33323130, 4'b0001, 2'd0, 8'h30};
        vecs[5]  = '{4'b0100, 32'h00C30000, 4'b0100, 2'd2, 8'hC3};
        vecs[6]  = '{4'b0011, 32'h0000965A, 4'b0001, 2'd0, 8'h5A};
        vecs[7]  = '{4'b0011, 32'h0000965A, 4'b0010, 2'd1, 8'h96};
        vecs[8]  = '{4'b0001, 32'h00000055, 4'b0001, 2'd0, 8'h55};
        vecs[9]  = '{4'b1000, 32'h01000000, 4'b1000, 2'd3, 8'h01};
        vecs[10] = '{4'b1001, 32'h7E000080, 4'b0001, 2'd0, 8'h80};
        vecs[11] = '{4'b1001, 32'h7E000080, 4'b1000, 2'd3, 8'h7E};

        bus1.req_valid = 4'b0000;
        bus1.req_data  = 32'h0;
        bus.req_valid  = vecs[0].valid;
        bus.req_data   = vecs[0].data;
        gprev = 0;

        // Reset state, with requests pending to prove req_ready is held low.
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_gid", 32'(grant_id), 32'd3);
        check("reset_ready", 32'(bus.req_ready), 32'd0);

        @(posedge clk); #1;
        reset_n = 1'b1;
        rx_en = 1'b1;
        rel = cyc;

        for (int i = 0; i < 12; i++) begin
            wait_grant("vec", vecs[i].exp_ready, vecs[i].exp_byte, g);
            check("vec_busy_at_grant", 32'(busy), 32'd0);
            if (i == 0) begin
                check("vec_first_edge", 32'(g - rel), 32'd0);
                check("vec_done_at_first", 32'(frame_done), 32'd0);
            end else begin
                check("vec_spacing", 32'(g - gprev), 32'(10 * CPB + 1));
                check("vec_done_at_grant", 32'(frame_done), 32'd1);
            end
            gprev = g;
            @(posedge clk); #1;
            if (i < 11) begin
                bus.req_valid = vecs[i + 1].valid;
                bus.req_data  = vecs[i + 1].data;
            end else begin
                bus.req_valid = 4'b0000;
            end
            @(negedge clk);
            check("vec_gid", 32'(grant_id), 32'(vecs[i].exp_gid));
            check("vec_busy", 32'(busy), 32'd1);
            check("vec_ready_off", 32'(bus.req_ready), 32'd0);
        end
        drain("vec_drain");

        // Bit-exact single frame of 0x55.
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h00000055;
        wait_grant("bitlvl", 4'b0001, 8'h55, g);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        frame = {1'b1, 8'h55, 1'b0};
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (c <= 40) check("bitlvl_tx", 32'(uart_tx), 32'(frame[(c - 1) / CPB]));
            check("bitlvl_busy", 32'(busy), 32'(c <= 40));
            check("bitlvl_done", 32'(frame_done), 32'(c == 41));
        end

        // Data change while a frame is in flight.
        @(posedge clk); #1;
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00A50000;
        wait_grant("midchg", 4'b0100, 8'hA5, g);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        repeat (10) @(negedge clk);
        bus.req_data = 32'h00FF0000;
        drain("midchg_drain");

        // Request raised and dropped entirely while busy.
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
        bus.req_data  = 32'h3C000000;
        wait_grant("dropped", 4'b1000, 8'h3C, g);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        saw = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (bus.req_ready != 4'b0000) saw = 1'b1;
            if (c == 10) bus.req_valid = 4'b0010;
            if (c == 15) bus.req_valid = 4'b0000;
        end
        check("dropped_no_ready", 32'(saw), 32'd0);
        check("dropped_gid", 32'(grant_id), 32'd3);
        drain("dropped_drain");

        // Reset asserted during data bit 3 of 0xF0.
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000F000;
        wait_grant("rst_pre", 4'b0010, 8'hF0, g);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        repeat (17) @(negedge clk);
        check("rst_pre_bit3", 32'(uart_tx), 32'd0);
        #2;
        rx_en = 1'b0;
        bus.req_valid = 4'b0011;
        bus.req_data  = 32'h00002211;
        reset_n = 1'b0;
        #1;
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd3);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        sb.delete();
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (frame_done || bus.req_ready != 4'b0000 || uart_tx != 1'b1) saw = 1'b1;
        end
        check("rst_quiet", 32'(saw), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rx_en = 1'b1;
        rel = cyc;
        wait_grant("rst_first", 4'b0001, 8'h11, g);
        check("rst_first_edge", 32'(g - rel), 32'd0);
        gprev = g;
        wait_grant("rst_second", 4'b0010, 8'h22, g);
        check("rst_second_spacing", 32'(g - gprev), 32'(10 * CPB + 1));
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        drain("rst_drain");

        // One clock per bit: no bit may be skipped.
        @(posedge clk); #1;
        bus1.req_valid = 4'b0001;
        bus1.req_data  = 32'h000000B4;
        t = 0;
        @(negedge clk);
        while (bus1.req_ready == 4'b0000 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cpb1_ready", 32'(bus1.req_ready), 32'd1);
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        frame = {1'b1, 8'hB4, 1'b0};
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 10) check("cpb1_tx", 32'(uart_tx1), 32'(frame[c - 1]));
            check("cpb1_done", 32'(frame_done1), 32'(c == 11));
        end
        check("cpb1_gid", 32'(grant_id1), 32'd0);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clock cycles per UART bit period (legal range 1..65535).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  4  per-requester byte-available flag; bit i belongs to requester i.
REQ-005 SHALL have port: req_data  input  32  per-requester byte; requester i at bits [8i+7:8i].
REQ-006 SHALL have port: req_ready  output  4  one-cycle accept pulse to the granted requester.
REQ-007 SHALL have port: uart_tx  output  1  serial line; idle high, 8N1 framing, LSB first.
REQ-008 SHALL have port: busy  output  1  high while a frame is in progress (state != IDLE).
REQ-009 SHALL have port: grant_id  output  2  index of the requester last granted.
REQ-010 SHALL have port: frame_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP; all outputs registered.
REQ-012 In IDLE with req_valid != 0, SHALL grant one requester by round-robin: search starts at (grant_id+1) mod 4 and wraps.
REQ-013 On grant cycle SHALL assert req_ready[k] for exactly that cycle for granted k only, latch req_data byte k, update grant_id to k, and move to START.
REQ-014 SHALL never assert more than one req_ready bit in a cycle, and never outside IDLE.
REQ-015 In IDLE with req_valid == 0 SHALL stay in IDLE, uart_tx = 1, grant_id unchanged.
REQ-016 START SHALL drive uart_tx = 0 for exactly CLKS_PER_BIT cycles, beginning the cycle after the grant.
REQ-017 DATA SHALL drive latched bits 0..7 in order, each for exactly CLKS_PER_BIT cycles.
REQ-018 STOP SHALL drive uart_tx = 1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 SHALL pulse frame_done in the first IDLE cycle after STOP; a new grant is legal in that same cycle.
REQ-020 Back-to-back frames SHALL therefore start every 10*CLKS_PER_BIT+1 cycles, with 1 idle-high cycle between stop and next start bit.
REQ-021 Bit timing SHALL use one internal down/up counter of width sufficient for 65535 and a 3-bit bit index; counter reloads at every bit boundary.
REQ-022 Changes of req_valid/req_data during START/DATA/STOP SHALL not affect the frame in flight.
REQ-023 A requester dropping req_valid before being granted SHALL simply not be granted; no error state.
REQ-024 busy SHALL be high from the cycle after the grant through the last STOP cycle.
REQ-025 With CLKS_PER_BIT = 1 the frame SHALL still be 10 cycles of line activity with no bit skipped.

Reset
REQ-026 While reset_n = 0 SHALL force: state IDLE, uart_tx = 1, req_ready = 0, busy = 0, frame_done = 0, grant_id = 3 (so requester 0 has first priority), counters 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately (uart_tx = 1 asynchronously), with no frame_done and no req_ready pulse.
REQ-028 After reset_n deasserts SHALL evaluate requests from the first rising clock edge.

Verification (CLKS_PER_BIT = 4)
REQ-029 Single request: req_valid=0001, byte0=0x55 -> req_ready=0001 one cycle; uart_tx = 0,1,0,1,0,1,0,1,0,1 each 4 cycles; frame_done 41 cycles after grant.
REQ-030 All requesting: req_valid=1111, bytes 0x30..0x33 held -> grants in order 0,1,2,3,0; grants spaced 41 cycles; serialized bytes match.
REQ-031 Fairness wrap: after grant 2, req_valid=0011 -> next grant is 0, then 1.
REQ-032 Mid-frame change: during DATA of 0xA5 change req_data byte to 0xFF -> line still carries 0xA5.
REQ-033 Reset mid-frame: assert reset_n=0 during bit 3 -> uart_tx=1 same cycle, busy=0, grant_id=3, no frame_done; after release requester 0 granted first.
REQ-034 Dropped request: req_valid[1] pulsed while busy, low again before IDLE -> no grant to 1, req_ready stays 0000.
